// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM stage: deserialises {cmd, payload} words and serialises read data on MISO.
// Optional `SPI_FRAME_ERR_EN adds a frame_err pulse for frames cut short by SS_n.
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int RX_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(RX_W);
    localparam int TXC_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    // Progress within a data state: shifting in, awaiting RAM data, shifting out, finished.
    typedef enum logic [1:0] {PH_SHIFT, PH_WAIT, PH_SEND, PH_DONE} phase_t;

    state_t            state;
    phase_t            phase;
    logic [RX_W-2:0]   rx_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] tx_shift;
    logic [TXC_W-1:0]  tx_cnt;
    logic              rd_addr_seen;

`ifdef SPI_FRAME_ERR_EN
    logic frame_complete;
    assign frame_complete = (phase == PH_DONE) ||
                            (phase == PH_SEND && tx_cnt == TXC_W'(DATA_W - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= PH_SHIFT;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    MISO    <= 1'b0;
                    phase   <= PH_SHIFT;
                    bit_cnt <= '0;
                    if (!SS_n)
                        state <= CHK_CMD;
                end
                CHK_CMD: begin
                    MISO    <= 1'b0;
                    phase   <= PH_SHIFT;
                    bit_cnt <= '0;
                    if (SS_n) begin
                        state <= IDLE;
`ifdef SPI_FRAME_ERR_EN
                        frame_err <= 1'b1;
`endif
                    end else if (!MOSI)
                        state <= WRITE;
                    else if (!rd_addr_seen)
                        state <= READ_ADD;
                    else
                        state <= READ_DATA;
                end
                default: begin
                    if (SS_n) begin
                        state <= IDLE;
                        MISO  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                        frame_err <= !frame_complete;
`endif
                    end else begin
                        case (phase)
                            PH_SHIFT: begin
                                MISO     <= 1'b0;
                                rx_shift <= {rx_shift[RX_W-3:0], MOSI};
                                bit_cnt  <= bit_cnt + 1'b1;
                                if (bit_cnt == CNT_W'(RX_W - 1)) begin
                                    rx_data  <= {rx_shift, MOSI};
                                    rx_valid <= 1'b1;
                                    if (state == READ_ADD)
                                        rd_addr_seen <= 1'b1;
                                    if (state == READ_DATA) begin
                                        rd_addr_seen <= 1'b0;
                                        phase        <= PH_WAIT;
                                    end else
                                        phase <= PH_DONE;
                                end
                            end
                            PH_WAIT: begin
                                MISO <= 1'b0;
                                if (tx_valid) begin
                                    MISO     <= tx_data[DATA_W-1];
                                    tx_shift <= tx_data[DATA_W-2:0];
                                    tx_cnt   <= '0;
                                    phase    <= PH_SEND;
                                end
                            end
                            PH_SEND: begin
                                if (tx_cnt == TXC_W'(DATA_W - 1)) begin
                                    MISO  <= 1'b0;
                                    phase <= PH_DONE;
                                end else begin
                                    MISO     <= tx_shift[DATA_W-2];
                                    tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
                                    tx_cnt   <= tx_cnt + 1'b1;
                                end
                            end
                            default: MISO <= 1'b0;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised self-checking bench for spi_slave_if against a transaction-level frame model.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int         checks = 0;
    int         errors = 0;
    bit         seen = 1'b0;
    logic [9:0] last_word = '0;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input logic exp);
`ifdef SPI_FRAME_ERR_EN
        check("frame_err", 32'(frame_err), 32'(exp));
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    // One SS_n-low transaction; abort_bit/abort_miso = -1 means no early deassert.
    task automatic run_frame(input logic sel, input logic [9:0] word, input int abort_bit,
                             input int abort_miso, input logic [7:0] tx_byte, input int delay);
        bit rd;
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        tick;
        check("idle_valid", 32'(rx_valid), 0);
        check("idle_miso", 32'(MISO), 0);
        MOSI = sel;
        tick;
        check("cmd_valid", 32'(rx_valid), 0);
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            if (i == abort_bit) begin
                SS_n = 1'b1;
                tick;
                tx_valid = 1'b0;
                check("abort_valid", 32'(rx_valid), 0);
                check("abort_miso", 32'(MISO), 0);
                check("abort_hold", 32'(rx_data), 32'(last_word));
                check_err(1'b1);
                return;
            end
            MOSI = word[9-i];
            tick;
            if (i < 9) check("shift_valid", 32'(rx_valid), 0);
            check("shift_miso", 32'(MISO), 0);
        end
        tx_valid = 1'b0;
        check("rx_valid", 32'(rx_valid), 1);
        check("rx_data", 32'(rx_data), 32'(word));
        last_word = word;
        rd = sel && seen;
        if (sel) seen = !seen;
        if (rd) begin
            for (int d = 0; d < delay; d++) begin
                tick;
                check("wait_valid", 32'(rx_valid), 0);
                check("wait_miso", 32'(MISO), 0);
            end
            tx_valid = 1'b1;
            tx_data  = tx_byte;
            tick;
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            check("rx_pulse", 32'(rx_valid), 0);
            check("miso_b7", 32'(MISO), 32'(tx_byte[7]));
            for (int b = 6; b >= 0; b--) begin
                tx_valid = 1'($urandom);
                tick;
                check("miso_bit", 32'(MISO), 32'(tx_byte[b]));
                if (b == abort_miso) begin
                    SS_n = 1'b1;
                    tx_valid = 1'b0;
                    tick;
                    check("miso_abort", 32'(MISO), 0);
                    check_err(1'b1);
                    return;
                end
            end
        end
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
        tick;
        check("done_valid", 32'(rx_valid), 0);
        check("done_miso", 32'(MISO), 0);
        tick;
        check("hold_miso", 32'(MISO), 0);
        tx_valid = 1'b0;
        SS_n = 1'b1;
        tick;
        check("end_miso", 32'(MISO), 0);
        check("end_hold", 32'(rx_data), 32'(last_word));
        check_err(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        #1;
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_miso", 32'(MISO), 0);
        check("rst_data", 32'(rx_data), 0);
        tick; tick;
        rst = 1'b0;
        tick;

        run_frame(1'b0, 10'h0A5, -1, -1, 8'h00, 0);
        run_frame(1'b0, 10'h13C, -1, -1, 8'h00, 0);
        run_frame(1'b1, 10'h207, -1, -1, 8'h00, 0);
        run_frame(1'b1, 10'h300, -1, -1, 8'hC3, 1);
        run_frame(1'b0, 10'h155, 5, -1, 8'h00, 0);
        run_frame(1'b0, 10'h2AA, -1, -1, 8'h00, 0);
        run_frame(1'b0, 10'h3FF, 9, -1, 8'h00, 0);
        run_frame(1'b1, 10'h211, -1, -1, 8'h00, 0);
        run_frame(1'b1, 10'h300, -1, 3, 8'hC3, 0);

        // Reset in the middle of a frame after an address phase leaves rd_addr_seen set.
        run_frame(1'b1, 10'h2F0, -1, -1, 8'h00, 0);
        SS_n = 1'b0; tick;
        MOSI = 1'b1; tick;
        for (int i = 0; i < 4; i++) begin MOSI = 1'($urandom); tick; end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_miso", 32'(MISO), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        seen = 1'b0;
        last_word = '0;
        SS_n = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        run_frame(1'b1, 10'h2C4, -1, -1, 8'h00, 0);
        run_frame(1'b1, 10'h3A1, -1, -1, 8'h5A, 2);

        for (int n = 0; n < 40; n++) begin
            run_frame(1'($urandom), 10'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1,
                      8'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
